// File: rtl/mem_pkg.sv
// Shared definitions for the data RAM responder and the memory controller
// that drives the LDR/STR bus protocol.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word array with write enable and registered read.
module ram_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for LDR/STR transactions on the shared tristate
// databus: latches a request, waits WAIT_STATES cycles, then pulses ready.
module ram_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              adr_select,
    input  logic              ram_rw,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] databus,
    output logic              ready,
    output logic              addr_err
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [DEPTH_LOG2-1:0]   lat_addr;
    logic                    lat_rw;
    logic                    lat_err;
    logic [DATA_W-1:0]       lat_wdata;
    logic                    oe;
    logic                    in_oor;
    logic                    arr_we;
    logic                    arr_re;
    logic [DEPTH_LOG2-1:0]   arr_addr;
    logic [DATA_W-1:0]       rd_data;

    assign in_oor = (address[ADDR_W-1:DEPTH_LOG2] != '0);

    // The array read must land on the edge that enters RESP, so with zero
    // wait states the address comes straight from the request inputs.
    always_comb begin
        arr_addr = lat_addr;
        arr_we   = 1'b0;
        arr_re   = 1'b0;
        case (state)
            IDLE: begin
                if (adr_select && (ram_rw == RW_READ) && (WS == 4'd0)) begin
                    arr_addr = address[DEPTH_LOG2-1:0];
                    arr_re   = 1'b1;
                end
            end
            WAIT: begin
                if ((wait_cnt == 4'd1) && (lat_rw == RW_READ)) begin
                    arr_re = 1'b1;
                end
            end
            RESP: begin
                if ((lat_rw == RW_WRITE) && !lat_err) begin
                    arr_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    ram_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (lat_wdata),
        .rdata (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_rw    <= RW_READ;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            ready     <= 1'b0;
            addr_err  <= 1'b0;
            oe        <= 1'b0;
        end else begin
            ready    <= 1'b0;
            addr_err <= 1'b0;
            oe       <= 1'b0;
            case (state)
                IDLE: begin
                    if (adr_select) begin
                        lat_addr <= address[DEPTH_LOG2-1:0];
                        lat_rw   <= ram_rw;
                        lat_err  <= in_oor;
                        wait_cnt <= WS;
                        if (ram_rw == RW_WRITE) begin
                            lat_wdata <= databus;
                        end
                        if (WS == 4'd0) begin
                            state    <= RESP;
                            ready    <= 1'b1;
                            addr_err <= in_oor;
                            oe       <= (ram_rw == RW_READ);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state    <= RESP;
                        ready    <= 1'b1;
                        addr_err <= lat_err;
                        oe       <= (lat_rw == RW_READ);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Out-of-range loads return zeros rather than an aliased word.
    assign databus = oe ? (lat_err ? '0 : rd_data) : 'z;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder against a word-array reference model.
module tb_ram_responder;

    localparam logic [31:0] IDLE_BUS = 32'hFFFF_FFFF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        adr_select;
    logic        ram_rw;
    logic [15:0] address;
    logic        tb_oe;
    logic [31:0] tb_data;
    wire  [31:0] bus;
    logic        ready;
    logic        addr_err;

    logic        h_sel;
    logic        h_rw;
    logic [15:0] h_addr;
    logic        h_oe;
    logic [31:0] h_data;
    wire  [31:0] bus0;
    wire  [31:0] bus3;
    logic        ready0;
    logic        err0;
    logic        ready3;
    logic        err3;

    assign bus  = tb_oe ? tb_data : 'z;
    assign bus0 = h_oe ? h_data : 'z;
    assign bus3 = h_oe ? h_data : 'z;
    pullup (bus);
    pullup (bus0);
    pullup (bus3);

    ram_responder #(.WAIT_STATES(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .adr_select (adr_select),
        .ram_rw     (ram_rw),
        .address    (address),
        .databus    (bus),
        .ready      (ready),
        .addr_err   (addr_err)
    );

    ram_responder #(.WAIT_STATES(0)) dut_ws0 (
        .clock      (clock),
        .reset_n    (reset_n),
        .adr_select (h_sel),
        .ram_rw     (h_rw),
        .address    (h_addr),
        .databus    (bus0),
        .ready      (ready0),
        .addr_err   (err0)
    );

    ram_responder #(.WAIT_STATES(3)) dut_ws3 (
        .clock      (clock),
        .reset_n    (reset_n),
        .adr_select (h_sel),
        .ram_rw     (h_rw),
        .address    (h_addr),
        .databus    (bus3),
        .ready      (ready3),
        .addr_err   (err3)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [256];
    bit          known [256];

    // Reference: 256 words, anything at or above 256 is out of range.
    function automatic void model_access(input logic rw, input logic [15:0] a,
                                         input logic [31:0] d,
                                         output logic [31:0] exp_d,
                                         output logic exp_err,
                                         output bit exp_known);
        int idx;
        idx       = int'(a);
        exp_err   = (idx >= 256);
        exp_d     = 32'h0;
        exp_known = 1'b1;
        if (!exp_err) begin
            if (rw) begin
                model[idx] = d;
                known[idx] = 1'b1;
                exp_known  = 1'b0;
            end else begin
                exp_d     = model[idx];
                exp_known = known[idx];
            end
        end
    endfunction

    // Starts and ends at a falling edge; lat = 0 means ready never came.
    task automatic txn(input logic rw, input logic [15:0] a, input logic [31:0] d,
                       output logic [31:0] got, output logic err, output int lat,
                       output logic after_ready, output logic [31:0] after_bus);
        adr_select = 1'b1;
        ram_rw     = rw;
        address    = a;
        tb_oe      = rw;
        tb_data    = d;
        @(posedge clock);
        @(negedge clock);
        adr_select = 1'b0;
        ram_rw     = 1'b0;
        address    = 16'h0;
        tb_oe      = 1'b0;
        lat        = 0;
        got        = 32'h0;
        err        = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (ready) begin
                lat = n;
                got = bus;
                err = addr_err;
                break;
            end
            @(negedge clock);
        end
        after_ready = 1'b1;
        after_bus   = 32'h0;
        if (lat != 0) begin
            @(negedge clock);
            after_ready = ready;
            after_bus   = bus;
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        adr_select = 1'b1;
        ram_rw     = 1'b0;
        address    = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (ready !== 1'b0 || addr_err !== 1'b0 || bus !== IDLE_BUS) begin
                errors++;
                $display("[TB] FAIL reset_hold: ready=%b addr_err=%b bus=%h, required 0 0 %h",
                         ready, addr_err, bus, IDLE_BUS);
            end
        end
        adr_select = 1'b0;
        reset_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (ready !== 1'b0 || bus !== IDLE_BUS) begin
                errors++;
                $display("[TB] FAIL reset_idle: ready=%b bus=%h, required 0 %h",
                         ready, bus, IDLE_BUS);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] got, after_bus, exp_d;
        logic err, after_ready, exp_err;
        bit exp_known;
        int lat;
        model_access(1'b1, 16'h0005, 32'hDEADBEEF, exp_d, exp_err, exp_known);
        txn(1'b1, 16'h0005, 32'hDEADBEEF, got, err, lat, after_ready, after_bus);
        checks++;
        if (lat !== 2 || got !== IDLE_BUS || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_latency: lat=%0d bus=%h err=%b, required 2 %h 0",
                     lat, got, err, IDLE_BUS);
        end
        model_access(1'b0, 16'h0005, 32'h0, exp_d, exp_err, exp_known);
        txn(1'b0, 16'h0005, 32'h0, got, err, lat, after_ready, after_bus);
        checks++;
        if (lat !== 2 || got !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_data: lat=%0d data=%h, required 2 deadbeef", lat, got);
        end
        checks++;
        if (after_ready !== 1'b0 || after_bus !== IDLE_BUS) begin
            errors++;
            $display("[TB] FAIL read_release: ready=%b bus=%h, required 0 %h",
                     after_ready, after_bus, IDLE_BUS);
        end
    endtask

    task automatic test_busy_inputs();
        logic [31:0] got, after_bus, exp_d;
        logic err, after_ready, exp_err;
        bit exp_known;
        int lat;
        model_access(1'b1, 16'h0011, 32'h0BADF00D, exp_d, exp_err, exp_known);
        txn(1'b1, 16'h0011, 32'h0BADF00D, got, err, lat, after_ready, after_bus);
        model_access(1'b1, 16'h0010, 32'h12345678, exp_d, exp_err, exp_known);
        adr_select = 1'b1;
        ram_rw     = 1'b1;
        address    = 16'h0010;
        tb_oe      = 1'b1;
        tb_data    = 32'h12345678;
        @(posedge clock);
        @(negedge clock);
        address = 16'h0011;
        tb_data = 32'hFFFFFFFF;
        @(negedge clock);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_ready: ready=%b, required 1", ready);
        end
        adr_select = 1'b0;
        ram_rw     = 1'b0;
        tb_oe      = 1'b0;
        @(negedge clock);
        txn(1'b0, 16'h0010, 32'h0, got, err, lat, after_ready, after_bus);
        checks++;
        if (got !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL busy_latched_data: data=%h, required 12345678", got);
        end
        txn(1'b0, 16'h0011, 32'h0, got, err, lat, after_ready, after_bus);
        checks++;
        if (got !== 32'h0BADF00D) begin
            errors++;
            $display("[TB] FAIL busy_other_addr: data=%h, required 0badf00d", got);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] got, after_bus, exp_d;
        logic err, after_ready, exp_err;
        bit exp_known;
        int lat;
        model_access(1'b1, 16'h0000, 32'h00C0FFEE, exp_d, exp_err, exp_known);
        txn(1'b1, 16'h0000, 32'h00C0FFEE, got, err, lat, after_ready, after_bus);
        model_access(1'b1, 16'h0100, 32'hAAAA5555, exp_d, exp_err, exp_known);
        txn(1'b1, 16'h0100, 32'hAAAA5555, got, err, lat, after_ready, after_bus);
        checks++;
        if (lat !== 2 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_write_err: lat=%0d err=%b, required 2 1", lat, err);
        end
        txn(1'b0, 16'h0100, 32'h0, got, err, lat, after_ready, after_bus);
        checks++;
        if (got !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_read: data=%h err=%b, required 00000000 1", got, err);
        end
        txn(1'b0, 16'h0000, 32'h0, got, err, lat, after_ready, after_bus);
        checks++;
        if (got !== 32'h00C0FFEE || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oor_no_alias: data=%h err=%b, required 00c0ffee 0", got, err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, after_bus, exp_d;
        logic err, after_ready, exp_err;
        bit exp_known;
        int lat;
        bit seen_ready;
        model_access(1'b1, 16'h0020, 32'h00000001, exp_d, exp_err, exp_known);
        txn(1'b1, 16'h0020, 32'h00000001, got, err, lat, after_ready, after_bus);
        adr_select = 1'b1;
        ram_rw     = 1'b1;
        address    = 16'h0020;
        tb_oe      = 1'b1;
        tb_data    = 32'hCAFEF00D;
        @(posedge clock);
        @(negedge clock);
        adr_select = 1'b0;
        ram_rw     = 1'b0;
        tb_oe      = 1'b0;
        reset_n    = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (ready) seen_ready = 1'b1;
            if (i == 2) reset_n = 1'b1;
        end
        checks++;
        if (seen_ready) begin
            errors++;
            $display("[TB] FAIL reset_mid_ready: ready pulsed, required none");
        end
        txn(1'b0, 16'h0020, 32'h0, got, err, lat, after_ready, after_bus);
        checks++;
        if (got !== 32'h00000001) begin
            errors++;
            $display("[TB] FAIL reset_mid_mem: data=%h, required 00000001", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, after_bus, exp_d, d;
        logic err, after_ready, exp_err;
        bit exp_known;
        int lat;
        d = $urandom;
        model_access(1'b1, 16'h0033, d, exp_d, exp_err, exp_known);
        txn(1'b1, 16'h0033, d, got, err, lat, after_ready, after_bus);
        model_access(1'b0, 16'h0033, 32'h0, exp_d, exp_err, exp_known);
        txn(1'b0, 16'h0033, 32'h0, got, err, lat, after_ready, after_bus);
        checks++;
        if (got !== exp_d) begin
            errors++;
            $display("[TB] FAIL back_to_back_raw: data=%h, required %h", got, exp_d);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, after_bus, exp_d, d;
        logic [15:0] a;
        logic err, after_ready, exp_err, rw;
        bit exp_known;
        int lat;
        for (int t = 0; t < 30; t++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(256, 65535));
            else a = 16'($urandom_range(0, 15));
            d = $urandom;
            model_access(rw, a, d, exp_d, exp_err, exp_known);
            txn(rw, a, d, got, err, lat, after_ready, after_bus);
            checks++;
            if (lat !== 2 || err !== exp_err) begin
                errors++;
                $display("[TB] FAIL rand_resp[%0d]: lat=%0d err=%b, required 2 %b", t, lat, err, exp_err);
            end
            if (rw) begin
                checks++;
                if (got !== IDLE_BUS) begin
                    errors++;
                    $display("[TB] FAIL rand_write_bus[%0d]: bus=%h, required undriven %h", t, got, IDLE_BUS);
                end
            end else if (exp_known) begin
                checks++;
                if (got !== exp_d) begin
                    errors++;
                    $display("[TB] FAIL rand_read[%0d] addr %h: data=%h, required %h", t, a, got, exp_d);
                end
            end
            checks++;
            if (after_ready !== 1'b0 || after_bus !== IDLE_BUS) begin
                errors++;
                $display("[TB] FAIL rand_release[%0d]: ready=%b bus=%h", t, after_ready, after_bus);
            end
        end
    endtask

    // Held request on the zero- and three-wait-state instances: ready period
    // must be WAIT_STATES+2 cycles and the bus stays undriven during stores.
    task automatic test_held();
        int last0, last3, cnt0, cnt3;
        h_sel  = 1'b1;
        h_addr = 16'h0005;
        h_data = 32'h5A5A0123;
        for (int phase = 0; phase < 2; phase++) begin
            h_rw  = (phase == 0);
            h_oe  = (phase == 0);
            h_sel = 1'b1;
            last0 = -1;
            last3 = -1;
            cnt0  = 0;
            cnt3  = 0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clock);
                if (ready0) begin
                    cnt0++;
                    if (last0 >= 0) begin
                        checks++;
                        if (n - last0 != 2) begin
                            errors++;
                            $display("[TB] FAIL held_period_ws0: interval=%0d, required 2", n - last0);
                        end
                    end
                    last0 = n;
                end
                if (ready3) begin
                    cnt3++;
                    if (last3 >= 0) begin
                        checks++;
                        if (n - last3 != 5) begin
                            errors++;
                            $display("[TB] FAIL held_period_ws3: interval=%0d, required 5", n - last3);
                        end
                    end
                    last3 = n;
                end
                checks++;
                if (phase == 0 && (bus0 !== h_data || bus3 !== h_data)) begin
                    errors++;
                    $display("[TB] FAIL held_write_bus: bus0=%h bus3=%h, required %h", bus0, bus3, h_data);
                end else if (phase == 1 &&
                             (bus0 !== (ready0 ? h_data : IDLE_BUS) ||
                              bus3 !== (ready3 ? h_data : IDLE_BUS))) begin
                    errors++;
                    $display("[TB] FAIL held_read_bus: bus0=%h bus3=%h ready0=%b ready3=%b",
                             bus0, bus3, ready0, ready3);
                end
            end
            if (phase == 1) begin
                checks++;
                if (cnt0 != 10 || cnt3 != 4) begin
                    errors++;
                    $display("[TB] FAIL held_pulse_count: ws0=%0d ws3=%0d, required 10 4", cnt0, cnt3);
                end
            end
            h_sel = 1'b0;
            h_oe  = 1'b0;
            for (int i = 0; i < 8; i++) @(negedge clock);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        adr_select = 1'b0;
        ram_rw     = 1'b0;
        address    = 16'h0;
        tb_oe      = 1'b0;
        tb_data    = 32'h0;
        h_sel      = 1'b0;
        h_rw       = 1'b0;
        h_addr     = 16'h0;
        h_oe       = 1'b0;
        h_data     = 32'h0;
        for (int i = 0; i < 256; i++) begin
            model[i] = 32'h0;
            known[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_busy_inputs();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
